// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, flag bit positions,
// sequencer state encoding and the opcode legality check.
package alu_pkg;

    localparam logic [7:0] OP_ADD                = 8'h00;
    localparam logic [7:0] OP_SUBTRACT           = 8'h01;
    localparam logic [7:0] OP_MULTIPLY           = 8'h02;
    localparam logic [7:0] OP_EQUALS             = 8'h03;
    localparam logic [7:0] OP_GREATER_THAN       = 8'h04;
    localparam logic [7:0] OP_ADD_IMMEDIATE      = 8'h09;
    localparam logic [7:0] OP_SUBTRACT_IMMEDIATE = 8'h0A;

    localparam int FLAG_OVF    = 4;
    localparam int FLAG_CARRY  = 3;
    localparam int FLAG_ZERO   = 2;
    localparam int FLAG_SIGN   = 1;
    localparam int FLAG_PARITY = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } seq_state_t;

    // Opcodes are passed zero-extended to 32 bits so any OPCODE_W can use this.
    function automatic logic opcode_is_legal(input logic [31:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            32'(OP_ADD), 32'(OP_SUBTRACT), 32'(OP_EQUALS), 32'(OP_GREATER_THAN),
            32'(OP_ADD_IMMEDIATE), 32'(OP_SUBTRACT_IMMEDIATE): legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: the winner is the first requester found
// searching upward from ptr_in+1 with wrap-around. The pointer register
// itself lives in the caller.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_in,
    input  logic [IDX_W-1:0]   ptr_in,
    output logic [NUM_REQ-1:0] grant_out,
    output logic [IDX_W-1:0]   grant_idx_out,
    output logic               any_out
);

    // Scan candidates in priority order and keep the first valid one.
    always_comb begin
        int cand;
        logic [IDX_W-1:0] cand_idx;
        grant_out     = '0;
        grant_idx_out = '0;
        any_out       = 1'b0;
        cand          = 0;
        cand_idx      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand     = (int'(ptr_in) + k) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!any_out && req_in[cand_idx]) begin
                grant_out[cand_idx] = 1'b1;
                grant_idx_out       = cand_idx;
                any_out             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Shares one combinational ALU between NUM_REQ requesters. Requests are
// arbitrated round-robin in IDLE, the ALU is driven for exactly one ISSUE
// cycle, and the captured result is offered on the response channel in RESP.
// Optional build macro ALU_SEQUENCER_OPCHECK_EN: illegal opcodes bypass the
// ALU and return data=0, flags=0 with rsp_err_out=1.
//
// Handshakes: a transfer happens on the rising clk_in edge where valid and
// ready are both high; valid and payload must stay stable until that edge,
// and ready never depends on anything the sender changes in reaction to it.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter  int NUM_REQ  = 4,
    parameter  int DATA_W   = 8,
    parameter  int OPCODE_W = 8,
    localparam int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                         clk_in,
    input  logic                         reset_in,
    input  logic [NUM_REQ-1:0]           req_valid_in,
    output logic [NUM_REQ-1:0]           req_ready_out,
    input  logic [NUM_REQ*OPCODE_W-1:0]  req_opcode_in,
    input  logic [NUM_REQ*DATA_W-1:0]    req_a_in,
    input  logic [NUM_REQ*DATA_W-1:0]    req_b_in,
    output logic                         alu_enable_out,
    output logic [OPCODE_W-1:0]          alu_opcode_out,
    output logic [DATA_W-1:0]            alu_input1_out,
    output logic [DATA_W-1:0]            alu_input2_out,
    input  logic [DATA_W-1:0]            alu_result_in,
    input  logic [4:0]                   alu_flags_in,
    output logic                         rsp_valid_out,
    input  logic                         rsp_ready_in,
    output logic [ID_W-1:0]              rsp_id_out,
    output logic [DATA_W-1:0]            rsp_data_out,
    output logic [4:0]                   rsp_flags_out,
    output logic                         rsp_err_out
);

    seq_state_t          state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [4:0]          flags_q, flags_d;
`ifdef ALU_SEQUENCER_OPCHECK_EN
    logic                err_q, err_d;
`endif

    logic [NUM_REQ-1:0]  grant_onehot;
    logic [ID_W-1:0]     grant_idx;
    logic                grant_any;
    logic [31:0]         op_ext;
    logic [4:0]          flags_cap;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_in        (req_valid_in),
        .ptr_in        (ptr_q),
        .grant_out     (grant_onehot),
        .grant_idx_out (grant_idx),
        .any_out       (grant_any)
    );

    // Captured flags: EQUALS and GREATER_THAN leave overflow, carry and
    // parity undriven in the ALU, so those bits are cleared here.
    always_comb begin
        op_ext    = 32'(op_q);
        flags_cap = alu_flags_in;
        if (op_ext == 32'(OP_EQUALS) || op_ext == 32'(OP_GREATER_THAN)) begin
            flags_cap[FLAG_OVF]    = 1'b0;
            flags_cap[FLAG_CARRY]  = 1'b0;
            flags_cap[FLAG_PARITY] = 1'b0;
        end
    end

    // Next-state and output logic for IDLE -> ISSUE -> RESP -> IDLE.
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        id_d           = id_q;
        op_d           = op_q;
        a_d            = a_q;
        b_d            = b_q;
        data_d         = data_q;
        flags_d        = flags_q;
`ifdef ALU_SEQUENCER_OPCHECK_EN
        err_d          = err_q;
`endif
        req_ready_out  = '0;
        alu_enable_out = 1'b0;
        alu_opcode_out = '0;
        alu_input1_out = '0;
        alu_input2_out = '0;
        rsp_valid_out  = 1'b0;
        case (state_q)
            IDLE: begin
                // Ready is gated by reset so every output reads 0 while held.
                if (grant_any && !reset_in) begin
                    req_ready_out = grant_onehot;
                    op_d    = req_opcode_in[int'(grant_idx)*OPCODE_W +: OPCODE_W];
                    a_d     = req_a_in[int'(grant_idx)*DATA_W +: DATA_W];
                    b_d     = req_b_in[int'(grant_idx)*DATA_W +: DATA_W];
                    ptr_d   = grant_idx;
                    id_d    = grant_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
`ifdef ALU_SEQUENCER_OPCHECK_EN
                if (opcode_is_legal(op_ext)) begin
                    alu_enable_out = 1'b1;
                    alu_opcode_out = op_q;
                    alu_input1_out = a_q;
                    alu_input2_out = b_q;
                    data_d         = alu_result_in;
                    flags_d        = flags_cap;
                    err_d          = 1'b0;
                end else begin
                    data_d  = '0;
                    flags_d = '0;
                    err_d   = 1'b1;
                end
`else
                alu_enable_out = 1'b1;
                alu_opcode_out = op_q;
                alu_input1_out = a_q;
                alu_input2_out = b_q;
                data_d         = alu_result_in;
                flags_d        = flags_cap;
`endif
                state_d = RESP;
            end
            RESP: begin
                rsp_valid_out = 1'b1;
                if (rsp_ready_in) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= IDLE;
            ptr_q   <= ID_W'(NUM_REQ - 1);
            id_q    <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            flags_q <= '0;
`ifdef ALU_SEQUENCER_OPCHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            flags_q <= flags_d;
`ifdef ALU_SEQUENCER_OPCHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign rsp_id_out    = id_q;
    assign rsp_data_out  = data_q;
    assign rsp_flags_out = flags_q;
`ifdef ALU_SEQUENCER_OPCHECK_EN
    assign rsp_err_out   = err_q;
`else
    assign rsp_err_out   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_alu_sequencer;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int OW = 8;

    logic              clk = 1'b0;
    logic              reset_in;
    logic [NR-1:0]     req_valid_in;
    logic [NR-1:0]     req_ready_out;
    logic [NR*OW-1:0]  req_opcode_in;
    logic [NR*DW-1:0]  req_a_in;
    logic [NR*DW-1:0]  req_b_in;
    logic              alu_enable_out;
    logic [OW-1:0]     alu_opcode_out;
    logic [DW-1:0]     alu_input1_out;
    logic [DW-1:0]     alu_input2_out;
    logic [DW-1:0]     alu_result_in;
    logic [4:0]        alu_flags_in;
    logic              rsp_valid_out;
    logic              rsp_ready_in;
    logic [1:0]        rsp_id_out;
    logic [DW-1:0]     rsp_data_out;
    logic [4:0]        rsp_flags_out;
    logic              rsp_err_out;

    int checks = 0;
    int errors = 0;

    // Clock
    always #5 clk = ~clk;

    alu_sequencer #(.NUM_REQ(NR), .DATA_W(DW), .OPCODE_W(OW)) dut (
        .clk_in         (clk),
        .reset_in       (reset_in),
        .req_valid_in   (req_valid_in),
        .req_ready_out  (req_ready_out),
        .req_opcode_in  (req_opcode_in),
        .req_a_in       (req_a_in),
        .req_b_in       (req_b_in),
        .alu_enable_out (alu_enable_out),
        .alu_opcode_out (alu_opcode_out),
        .alu_input1_out (alu_input1_out),
        .alu_input2_out (alu_input2_out),
        .alu_result_in  (alu_result_in),
        .alu_flags_in   (alu_flags_in),
        .rsp_valid_out  (rsp_valid_out),
        .rsp_ready_in   (rsp_ready_in),
        .rsp_id_out     (rsp_id_out),
        .rsp_data_out   (rsp_data_out),
        .rsp_flags_out  (rsp_flags_out),
        .rsp_err_out    (rsp_err_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference 8-bit ALU: returns {ovf, carry, zero, sign, parity, result}.
    function automatic logic [12:0] alu_ref(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        logic [7:0] r;
        logic ovf, cy;
        s = 9'd0; r = 8'd0; ovf = 1'b0; cy = 1'b0;
        case (op)
            8'h00, 8'h09: begin
                s = {1'b0, a} + {1'b0, b}; r = s[7:0]; cy = s[8];
                ovf = (a[7] == b[7]) && (r[7] != a[7]);
            end
            8'h01, 8'h0A: begin
                s = {1'b0, a} - {1'b0, b}; r = s[7:0]; cy = s[8];
                ovf = (a[7] != b[7]) && (r[7] != a[7]);
            end
            8'h03: r = (a == b) ? 8'd1 : 8'd0;
            8'h04: r = (a > b) ? 8'd1 : 8'd0;
            default: return 13'd0;
        endcase
        return {ovf, cy, (r == 8'd0), r[7], ^r, r};
    endfunction

    function automatic logic is_legal(input logic [7:0] op);
        return (op == 8'h00) || (op == 8'h01) || (op == 8'h03) || (op == 8'h04) ||
               (op == 8'h09) || (op == 8'h0A);
    endfunction

    // Expected response {err, flags, data} for one accepted request.
    function automatic logic [13:0] exp_rsp(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [12:0] r;
        logic [4:0] f;
`ifdef ALU_SEQUENCER_OPCHECK_EN
        if (!is_legal(op)) return {1'b1, 5'd0, 8'd0};
`endif
        r = alu_ref(op, a, b);
        f = r[12:8];
        if (op == 8'h03 || op == 8'h04) f = f & 5'b00110;
        return {1'b0, f, r[7:0]};
    endfunction

    function automatic int rr_pick(input logic [NR-1:0] v, input int ptr);
        for (int k = 1; k <= NR; k++) begin
            if (v[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    // Stand-in ALU: junk when disabled and in the bits EQUALS/GREATER_THAN leave undriven.
    logic [7:0]  junk;
    logic [12:0] alu_r;
    always @(posedge clk) junk <= 8'($urandom);
    always_comb begin
        alu_r = alu_ref(alu_opcode_out, alu_input1_out, alu_input2_out);
        if (!alu_enable_out) begin
            alu_result_in = junk;
            alu_flags_in  = junk[4:0];
        end else begin
            alu_result_in = alu_r[7:0];
            alu_flags_in  = alu_r[12:8];
            if (alu_opcode_out == 8'h03 || alu_opcode_out == 8'h04)
                alu_flags_in = alu_flags_in | (junk[4:0] & 5'b11001);
        end
    end

    // Transaction-level model: in flight or not, cycles since acceptance, pointer, expected response.
    logic          m_busy;
    int            m_age;
    int            m_ptr;
    logic [NR-1:0] m_pending;
    logic [1:0]    m_id;
    logic [7:0]    m_op, m_a, m_b, m_data;
    logic [4:0]    m_flags;
    logic          m_err;

    always @(posedge clk or posedge reset_in) begin : model
        int w;
        if (reset_in) begin
            m_busy = 1'b0; m_age = 0; m_ptr = NR - 1; m_pending = '0;
        end else begin
            for (int i = 0; i < NR; i++)
                if (m_pending[i]) chk("req_hold_valid", 32'(req_valid_in[i]), 32'd1);
            m_pending = req_valid_in;
            if (!m_busy) begin
                w = rr_pick(req_valid_in, m_ptr);
                if (w >= 0) begin
                    m_pending[w] = 1'b0;
                    m_busy = 1'b1; m_age = 1; m_ptr = w; m_id = 2'(w);
                    m_op = req_opcode_in[w*OW +: OW];
                    m_a  = req_a_in[w*DW +: DW];
                    m_b  = req_b_in[w*DW +: DW];
                    {m_err, m_flags, m_data} = exp_rsp(m_op, m_a, m_b);
                end
            end else if (m_age == 1) begin
                m_age = 2;
            end else if (rsp_ready_in) begin
                m_busy = 1'b0;
            end
        end
    end

    // Compare process: every output checked against the model on each falling edge.
    always @(negedge clk) begin : compare
        logic [NR-1:0] er;
        int w;
        logic en;
        if (reset_in) begin
            chk("rst_req_ready", 32'(req_ready_out), 32'd0);
            chk("rst_alu_enable", 32'(alu_enable_out), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid_out), 32'd0);
            chk("rst_rsp_data", 32'(rsp_data_out), 32'd0);
            chk("rst_rsp_flags", 32'(rsp_flags_out), 32'd0);
            chk("rst_rsp_id", 32'(rsp_id_out), 32'd0);
            chk("rst_rsp_err", 32'(rsp_err_out), 32'd0);
        end else begin
            er = '0;
            if (!m_busy) begin
                w = rr_pick(req_valid_in, m_ptr);
                if (w >= 0) er[w] = 1'b1;
            end
            chk("req_ready", 32'(req_ready_out), 32'(er));
`ifdef ALU_SEQUENCER_OPCHECK_EN
            en = m_busy && (m_age == 1) && is_legal(m_op);
`else
            en = m_busy && (m_age == 1);
`endif
            chk("alu_enable", 32'(alu_enable_out), 32'(en));
            chk("alu_opcode", 32'(alu_opcode_out), en ? 32'(m_op) : 32'd0);
            chk("alu_input1", 32'(alu_input1_out), en ? 32'(m_a) : 32'd0);
            chk("alu_input2", 32'(alu_input2_out), en ? 32'(m_b) : 32'd0);
            chk("rsp_valid", 32'(rsp_valid_out), 32'(m_busy && m_age >= 2));
            if (m_busy && m_age >= 2) begin
                chk("rsp_id", 32'(rsp_id_out), 32'(m_id));
                chk("rsp_data", 32'(rsp_data_out), 32'(m_data));
                chk("rsp_flags", 32'(rsp_flags_out), 32'(m_flags));
                chk("rsp_err", 32'(rsp_err_out), 32'(m_err));
            end
        end
    end

    // Driver tasks
    task automatic arm(input int i, input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        req_opcode_in[i*OW +: OW] = op;
        req_a_in[i*DW +: DW]      = a;
        req_b_in[i*DW +: DW]      = b;
        req_valid_in[i]           = 1'b1;
    endtask

    // Waits for an accept; returns at 2 ns after the accepting edge (g=-1 on timeout).
    task automatic wait_grant(output int g);
        int n;
        g = -1;
        n = 0;
        while (n < 60 && g < 0) begin
            @(negedge clk);
            for (int i = 0; i < NR; i++)
                if (req_valid_in[i] && req_ready_out[i]) g = i;
            n++;
        end
        if (g < 0) begin
            checks++; errors++;
            $display("FAIL accept_timeout actual=none expected=grant t=%0t", $time);
        end
        @(posedge clk); #2;
    endtask

    task automatic accept_and_drop(output int g);
        wait_grant(g);
        if (g >= 0) req_valid_in[g] = 1'b0;
        else req_valid_in = '0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (n < 60 && !rsp_valid_out) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid_out) begin
            checks++; errors++;
            $display("FAIL rsp_timeout actual=0 expected=1 t=%0t", $time);
        end
        @(posedge clk); #2;
    endtask

    task automatic do_reset();
        reset_in = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset_in = 1'b0;
    endtask

    function automatic logic [7:0] rand_op();
        logic [7:0] ops [8];
        ops = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h09, 8'h0A, 8'h00};
        if ($urandom_range(0, 15) == 0) return 8'($urandom_range(0, 255));
        return ops[$urandom_range(0, 7)];
    endfunction

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int g;
        int exp_order [8];
        logic [NR-1:0] acc;
        exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
        reset_in = 1'b1;
        req_valid_in = '0;
        req_opcode_in = '0;
        req_a_in = '0;
        req_b_in = '0;
        rsp_ready_in = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_in = 1'b0;

        // ADD 0x7F+0x01 from requester 2, response two cycles after accept.
        rsp_ready_in = 1'b1;
        arm(2, 8'h00, 8'h7F, 8'h01);
        accept_and_drop(g);
        @(negedge clk);
        chk("t1_issue_enable", 32'(alu_enable_out), 32'd1);
        chk("t1_issue_rsp_valid", 32'(rsp_valid_out), 32'd0);
        @(negedge clk);
        chk("t1_rsp_valid", 32'(rsp_valid_out), 32'd1);
        chk("t1_rsp_id", 32'(rsp_id_out), 32'd2);
        chk("t1_rsp_data", 32'(rsp_data_out), 32'h80);
        chk("t1_rsp_flags", 32'(rsp_flags_out), 32'b10011);
        @(posedge clk); #2;

        // SUBTRACT 0x00-0x01 from requester 0.
        arm(0, 8'h01, 8'h00, 8'h01);
        accept_and_drop(g);
        @(negedge clk);
        @(negedge clk);
        chk("t2_rsp_data", 32'(rsp_data_out), 32'hFF);
        chk("t2_rsp_flags", 32'(rsp_flags_out), 32'b01010);
        chk("t2_rsp_id", 32'(rsp_id_out), 32'd0);
        @(posedge clk); #2;

        // All requesters valid continuously: grant order 0,1,2,3,0,1,2,3.
        do_reset();
        for (int i = 0; i < NR; i++) arm(i, rand_op(), 8'($urandom), 8'($urandom));
        for (int k = 0; k < 8; k++) begin
            wait_grant(g);
            if (g < 0) begin
                req_valid_in = '0;
                break;
            end
            chk("rr_order", 32'(g), 32'(exp_order[k]));
            if (k < 4) arm(g, rand_op(), 8'($urandom), 8'($urandom));
            else req_valid_in[g] = 1'b0;
        end
        wait_rsp();

        // EQUALS 5,5 with back-pressure; a competing request must wait.
        rsp_ready_in = 1'b0;
        arm(1, 8'h03, 8'h05, 8'h05);
        accept_and_drop(g);
        arm(3, 8'h00, 8'h10, 8'h20);
        @(negedge clk);
        @(negedge clk);
        chk("t4_rsp_data", 32'(rsp_data_out), 32'h01);
        chk("t4_rsp_flags", 32'(rsp_flags_out), 32'b00000);
        repeat (5) begin
            @(negedge clk);
            chk("t4_hold_valid", 32'(rsp_valid_out), 32'd1);
            chk("t4_hold_data", 32'(rsp_data_out), 32'h01);
            chk("t4_hold_id", 32'(rsp_id_out), 32'd1);
            chk("t4_hold_ready", 32'(req_ready_out), 32'd0);
        end
        @(posedge clk); #2;
        rsp_ready_in = 1'b1;
        accept_and_drop(g);
        chk("t4_next_grant", 32'(g), 32'd3);
        wait_rsp();

        // Reset during ISSUE with requester 1 in flight; next grant must be 0.
        do_reset();
        arm(1, 8'h00, 8'h33, 8'h44);
        accept_and_drop(g);
        reset_in = 1'b1;
        #1;
        chk("t5_rst_rsp_valid", 32'(rsp_valid_out), 32'd0);
        chk("t5_rst_alu_enable", 32'(alu_enable_out), 32'd0);
        #1 reset_in = 1'b0;
        @(posedge clk); #2;
        arm(0, 8'h09, 8'h01, 8'h02);
        arm(3, 8'h0A, 8'h05, 8'h03);
        accept_and_drop(g);
        chk("t5_grant_after_reset", 32'(g), 32'd0);
        accept_and_drop(g);
        chk("t5_second_grant", 32'(g), 32'd3);
        wait_rsp();

        // Illegal opcode 0x02.
        arm(2, 8'h02, 8'h12, 8'h34);
        accept_and_drop(g);
        @(negedge clk);
`ifdef ALU_SEQUENCER_OPCHECK_EN
        chk("t6_alu_enable", 32'(alu_enable_out), 32'd0);
`else
        chk("t6_alu_enable", 32'(alu_enable_out), 32'd1);
`endif
        @(negedge clk);
        chk("t6_rsp_data", 32'(rsp_data_out), 32'h00);
        chk("t6_rsp_flags", 32'(rsp_flags_out), 32'd0);
`ifdef ALU_SEQUENCER_OPCHECK_EN
        chk("t6_rsp_err", 32'(rsp_err_out), 32'd1);
`else
        chk("t6_rsp_err", 32'(rsp_err_out), 32'd0);
`endif
        @(posedge clk); #2;

        // Randomized traffic with random back-pressure.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            acc = req_valid_in & req_ready_out;
            @(posedge clk); #2;
            for (int i = 0; i < NR; i++) begin
                if (acc[i]) req_valid_in[i] = 1'b0;
                if (!req_valid_in[i] && $urandom_range(0, 3) == 0)
                    arm(i, rand_op(), 8'($urandom), 8'($urandom));
            end
            rsp_ready_in = ($urandom_range(0, 9) < 7);
        end

        // Drain outstanding requests.
        rsp_ready_in = 1'b1;
        for (int c = 0; c < 100 && req_valid_in != '0; c++) begin
            @(negedge clk);
            acc = req_valid_in & req_ready_out;
            @(posedge clk); #2;
            req_valid_in = req_valid_in & ~acc;
        end
        repeat (6) @(posedge clk);
        #2;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
